button_event_ctrl: RTL and testbench
====================================

Name: button_event_ctrl

Overview:
Turns the debounced push-button levels (one button_debouncer per key) into discrete, timestamp-ordered user events: PRESS, RELEASE, LONG and REPEAT.
- A per-button state machine times each hold.
- A round-robin arbiter shares one event output, with a valid/ready handshake, among all buttons.
- Sits between the debouncers and the mic-array control logic (gain/mode/channel select).

Parameters:
NUM_BTN, 4, number of debounced buttons (1..8)
PB_ACTIVE_LOW, 1, 1 = pb_db bit low means pressed (DE-board keys); 0 = high means pressed
LONG_CYCLES, 50000000, hold time before LONG event (1 s at 50 MHz); must be >= 2
REPEAT_CYCLES, 10000000, period of REPEAT events after LONG (200 ms); must be >= 2

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset, synchronous, active-low
pb_db  in  NUM_BTN  debounced button levels, already synchronous to clk
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event when high with evt_valid
evt_btn  out  3  index of button that produced the event
evt_type  out  2  0 = PRESS, 1 = RELEASE, 2 = LONG, 3 = REPEAT
btn_held  out  NUM_BTN  live pressed state per button (polarity-normalised, 1 = pressed)
evt_ovf  out  1  sticky: an event was dropped because its pending slot was already full
ovf_clr  in  1  single-cycle clear of evt_ovf

Behaviour:
- Reset (rst_n low at a clk edge) clears:
  - all FSMs to IDLE, counters and pending bits to 0
  - evt_valid = 0, evt_btn = 0, evt_type = 0, btn_held = 0, evt_ovf = 0
  - Applies mid-operation too: an in-flight event is discarded.
- Normalisation: p[i] = pb_db[i] ^ PB_ACTIVE_LOW. btn_held is registered p, so it lags by 1 cycle.
- Per-button FSM states:
  - IDLE: p=1 -> HOLD; post PRESS; cnt = 0.
  - HOLD: p=0 -> IDLE, post RELEASE. Otherwise cnt++; when cnt == LONG_CYCLES-1, post LONG, cnt = 0, go to RPT.
  - RPT: p=0 -> IDLE, post RELEASE. Otherwise cnt++; when cnt == REPEAT_CYCLES-1, post REPEAT, cnt = 0.
  - LOCK: entered instead of HOLD if p=1 on the first cycle after reset deassertion. Posts nothing; goes to IDLE when p=0. A key held through reset therefore produces no events.
- Counter width is clog2(max(LONG_CYCLES, REPEAT_CYCLES)). The counter never wraps: it is cleared on every transition.
- Pending store: one bit per (button, type).
  - Posting sets the bit.
  - Posting while that bit is already set drops the event (coalesced) and sets evt_ovf.
  - ovf_clr and a same-cycle new overflow together leave evt_ovf = 1.
- Arbiter selects a button, then a type within it:
  - Button: round-robin across buttons with any pending bit, starting after the last granted index.
  - Type within the button: PRESS > LONG > REPEAT > RELEASE. This preserves causality because RELEASE is always generated last.
- Output register:
  - Loads when evt_valid == 0, or when evt_valid && evt_ready (back-to-back, no bubble).
  - The granted pending bit clears on load.
  - While evt_valid && !evt_ready, evt_btn and evt_type hold stable.
- Latency: pb_db change at edge E0 is seen by the FSM at E0 (pending set). evt_valid rises after E1: 2 cycles, uncontended.
- Simultaneous events:
  - A post and a grant of the same pending bit in one cycle: the grant wins the old event, and the new post re-sets the bit. No overflow.
  - Multiple buttons changing together: all are posted, then drained one per accepted cycle.

Decomposition:
- Package button_evt_pkg: EVT_PRESS/RELEASE/LONG/REPEAT encodings, FSM state encoding (IDLE, HOLD, RPT, LOCK), evt_type width.
- Sub-module button_event_fsm (one per button, generate loop): holds the FSM and counter; outputs 4 one-cycle post strobes.
- Top keeps the pending bits, arbiter, output register and evt_ovf.

Test Plan (bench uses LONG_CYCLES=8, REPEAT_CYCLES=4, PB_ACTIVE_LOW=1, evt_ready=1 unless stated):
1. Reset with all pb_db=1; drive pb_db[0]=0 for 3 cycles, then 1.
   -> PRESS (btn 0) 2 cycles after the fall, RELEASE (btn 0) 2 cycles after the rise; no LONG; evt_ovf = 0.
2. Hold pb_db[2]=0 for 20 cycles.
   -> PRESS, LONG 8 cycles after the PRESS post, REPEAT at +4 and +8, RELEASE on release.
3. pb_db[1] and pb_db[3] fall on the same edge.
   -> PRESS btn 1 then PRESS btn 3 on consecutive cycles.
   -> Next simultaneous press with last grant = 1: btn 3 is granted first.
4. evt_ready=0 during a button-0 press/release, then 2 more presses.
   -> evt_valid held with payload stable; second PRESS coalesced; evt_ovf = 1.
   -> ovf_clr -> evt_ovf = 0.
5. Hold pb_db[0]=0 while asserting rst_n=0 for 2 cycles, release reset, keep held 12 cycles, then release.
   -> no events at all (LOCK); the next press yields a normal PRESS.
6. Assert rst_n=0 while evt_valid=1 and ready=0.
   -> evt_valid = 0 and pending cleared on the next edge.

Source files
------------

// File: rtl/button_evt_pkg.sv
// Shared encodings for the push-button event controller: event types,
// per-button FSM states and the hold-counter width helper.
package button_evt_pkg;

    localparam int EVT_TYPE_W = 2;
    localparam int NUM_EVT    = 4;

    typedef enum logic [EVT_TYPE_W-1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2,
        ST_LOCK = 2'd3
    } btn_state_e;

    // Hold counter must reach the larger of the two periods minus one.
    function automatic int cnt_width(input int long_cycles, input int repeat_cycles);
        int max_v;
        max_v = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
        return ($clog2(max_v) < 1) ? 1 : $clog2(max_v);
    endfunction

endpackage

// File: rtl/button_event_fsm.sv
// Per-button hold timer: turns one normalised pressed level into one-cycle
// PRESS / RELEASE / LONG / REPEAT post strobes (indexed by evt_type_e).
module button_event_fsm
    import button_evt_pkg::*;
#(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pressed,
    output logic [NUM_EVT-1:0] post
);

    localparam int             CW          = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0]  LONG_LAST   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0]  REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    btn_state_e    state_r;
    btn_state_e    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          first_r;

    // State, counter and "first cycle after reset" flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            first_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            first_r <= 1'b0;
        end
    end

    // Next-state, counter and post strobes; counter clears on every transition.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        post        = {NUM_EVT{1'b0}};
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = {CW{1'b0}};
                if (pressed) begin
                    if (first_r) begin
                        // Key held through reset: swallow this whole hold.
                        state_nxt_s = ST_LOCK;
                    end else begin
                        state_nxt_s     = ST_HOLD;
                        post[EVT_PRESS] = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!pressed) begin
                    state_nxt_s       = ST_IDLE;
                    cnt_nxt_s         = {CW{1'b0}};
                    post[EVT_RELEASE] = 1'b1;
                end else if (cnt_r == LONG_LAST) begin
                    state_nxt_s    = ST_RPT;
                    cnt_nxt_s      = {CW{1'b0}};
                    post[EVT_LONG] = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            ST_RPT: begin
                if (!pressed) begin
                    state_nxt_s       = ST_IDLE;
                    cnt_nxt_s         = {CW{1'b0}};
                    post[EVT_RELEASE] = 1'b1;
                end else if (cnt_r == REPEAT_LAST) begin
                    cnt_nxt_s        = {CW{1'b0}};
                    post[EVT_REPEAT] = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            ST_LOCK: begin
                cnt_nxt_s = {CW{1'b0}};
                if (!pressed) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Push-button event controller: one hold-timer FSM per key, a pending bit per
// (button, type), a round-robin arbiter and a valid/ready event register.
module button_event_ctrl
    import button_evt_pkg::*;
#(
    parameter int NUM_BTN       = 4,
    parameter bit PB_ACTIVE_LOW = 1'b1,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_BTN-1:0]    pb_db,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [2:0]            evt_btn,
    output logic [EVT_TYPE_W-1:0] evt_type,
    output logic [NUM_BTN-1:0]    btn_held,
    output logic                  evt_ovf,
    input  logic                  ovf_clr
);

    logic [NUM_BTN-1:0]              pressed_s;
    logic [NUM_BTN-1:0][NUM_EVT-1:0] post_s;
    logic [NUM_BTN-1:0][NUM_EVT-1:0] pend_r;
    logic [NUM_BTN-1:0][NUM_EVT-1:0] gnt_s;
    logic [NUM_EVT-1:0]              sel_pend_s;
    logic [2:0]                      last_r;
    logic [2:0]                      gnt_btn_s;
    evt_type_e                       gnt_type_s;
    logic                            found_s;
    logic                            load_s;
    logic                            ovf_new_s;

    assign pressed_s = pb_db ^ {NUM_BTN{PB_ACTIVE_LOW}};
    assign load_s    = !evt_valid || evt_ready;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_fsm
        button_event_fsm #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_fsm (
            .clk     (clk),
            .rst_n   (rst_n),
            .pressed (pressed_s[g]),
            .post    (post_s[g])
        );
    end

    // Round-robin button pick: first button with anything pending after last_r.
    always_comb begin
        int idx;
        found_s    = 1'b0;
        gnt_btn_s  = 3'd0;
        sel_pend_s = {NUM_EVT{1'b0}};
        for (int k = 1; k <= NUM_BTN; k++) begin
            idx = int'(last_r) + k;
            if (idx >= NUM_BTN) begin
                idx = idx - NUM_BTN;
            end else begin
                idx = idx;
            end
            if (!found_s && (|pend_r[idx])) begin
                found_s    = 1'b1;
                gnt_btn_s  = 3'(idx);
                sel_pend_s = pend_r[idx];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Type within the chosen button; RELEASE last keeps events causal.
    always_comb begin
        if (sel_pend_s[EVT_PRESS]) begin
            gnt_type_s = EVT_PRESS;
        end else if (sel_pend_s[EVT_LONG]) begin
            gnt_type_s = EVT_LONG;
        end else if (sel_pend_s[EVT_REPEAT]) begin
            gnt_type_s = EVT_REPEAT;
        end else begin
            gnt_type_s = EVT_RELEASE;
        end
    end

    // One-hot mask of the pending bit consumed by this cycle's load.
    always_comb begin
        gnt_s = '0;
        for (int b = 0; b < NUM_BTN; b++) begin
            for (int t = 0; t < NUM_EVT; t++) begin
                gnt_s[b][t] = load_s && found_s && (b == int'(gnt_btn_s)) && (t == int'(gnt_type_s));
            end
        end
    end

    // A post finding its bit still set (and not granted now) is coalesced.
    assign ovf_new_s = |(pend_r & ~gnt_s & post_s);

    // Pending store, output register, sticky overflow and held levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_r    <= '0;
            last_r    <= 3'd0;
            evt_valid <= 1'b0;
            evt_btn   <= 3'd0;
            evt_type  <= EVT_PRESS;
            btn_held  <= {NUM_BTN{1'b0}};
            evt_ovf   <= 1'b0;
        end else begin
            pend_r   <= (pend_r & ~gnt_s) | post_s;
            btn_held <= pressed_s;
            evt_ovf  <= (evt_ovf & ~ovf_clr) | ovf_new_s;
            if (load_s) begin
                evt_valid <= found_s;
                if (found_s) begin
                    evt_btn  <= gnt_btn_s;
                    evt_type <= gnt_type_s;
                    last_r   <= gnt_btn_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl: an age-based event model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_button_event_ctrl;

    localparam int NB   = 4;
    localparam int LC   = 8;
    localparam int RC   = 4;
    localparam bit PBAL = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] pb_db;
    logic          evt_valid;
    logic          evt_ready;
    logic [2:0]    evt_btn;
    logic [1:0]    evt_type;
    logic [NB-1:0] btn_held;
    logic          evt_ovf;
    logic          ovf_clr;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    button_event_ctrl #(
        .NUM_BTN       (NB),
        .PB_ACTIVE_LOW (PBAL),
        .LONG_CYCLES   (LC),
        .REPEAT_CYCLES (RC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pb_db     (pb_db),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_btn   (evt_btn),
        .evt_type  (evt_type),
        .btn_held  (btn_held),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic expect_evt(input string nm, input int b, input int t);
        chk({nm, ".valid"}, 32'(evt_valid), 32'd1);
        chk({nm, ".btn"},   32'(evt_btn),   32'(b));
        chk({nm, ".type"},  32'(evt_type),  32'(t));
    endtask

    task automatic expect_none(input string nm);
        chk({nm, ".valid"}, 32'(evt_valid), 32'd0);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 released, 1 held (age = cycles since PRESS post), 2 locked
    int       m_mode[NB];
    int       m_age[NB];
    bit [3:0] m_pend[NB];
    bit       m_valid;
    int       m_btn;
    int       m_type;
    bit       m_ovf;
    bit [NB-1:0] m_held;
    int       m_last;
    bit       m_first;
    int       prio[4] = '{0, 2, 3, 1};

    // Model update on every active edge from the sampled inputs.
    always @(posedge clk) begin : mdl
        logic [NB-1:0] p;
        bit [3:0]      post[NB];
        bit            found;
        bit            new_ovf;
        int            b;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                m_mode[i] = 0; m_age[i] = 0; m_pend[i] = 4'd0;
            end
            m_valid = 1'b0; m_btn = 0; m_type = 0; m_ovf = 1'b0;
            m_held = '0; m_last = 0; m_first = 1'b1;
        end else begin
            p = pb_db ^ {NB{PBAL}};
            for (int i = 0; i < NB; i++) begin
                post[i] = 4'd0;
                if (m_mode[i] == 0) begin
                    if (p[i]) begin
                        if (m_first) m_mode[i] = 2;
                        else begin m_mode[i] = 1; m_age[i] = 0; post[i][0] = 1'b1; end
                    end
                end else if (m_mode[i] == 1) begin
                    if (!p[i]) begin m_mode[i] = 0; post[i][1] = 1'b1; end
                    else begin
                        m_age[i]++;
                        if (m_age[i] == LC) post[i][2] = 1'b1;
                        else if (m_age[i] > LC && ((m_age[i] - LC) % RC) == 0) post[i][3] = 1'b1;
                    end
                end else begin
                    if (!p[i]) m_mode[i] = 0;
                end
            end
            m_first = 1'b0;
            if (!m_valid || evt_ready) begin
                found = 1'b0;
                for (int k = 1; k <= NB; k++) begin
                    b = (m_last + k) % NB;
                    if (!found && m_pend[b] != 4'd0) begin
                        found = 1'b1;
                        for (int j = 3; j >= 0; j--) if (m_pend[b][prio[j]]) m_type = prio[j];
                        m_btn = b;
                    end
                end
                m_valid = found;
                if (found) begin
                    m_pend[m_btn][m_type] = 1'b0;
                    m_last = m_btn;
                end
            end
            new_ovf = 1'b0;
            for (int i = 0; i < NB; i++)
                for (int t = 0; t < 4; t++)
                    if (post[i][t]) begin
                        if (m_pend[i][t]) new_ovf = 1'b1;
                        else m_pend[i][t] = 1'b1;
                    end
            m_ovf  = (m_ovf && !ovf_clr) || new_ovf;
            m_held = p;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("mdl.valid", 32'(evt_valid), 32'(m_valid));
            if (m_valid) begin
                chk("mdl.btn",  32'(evt_btn),  32'(m_btn));
                chk("mdl.type", 32'(evt_type), 32'(m_type));
            end
            chk("mdl.held", 32'(btn_held), 32'(m_held));
            chk("mdl.ovf",  32'(evt_ovf),  32'(m_ovf));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; pb_db = 4'hF; evt_ready = 1'b1; ovf_clr = 1'b0;
        step(3);
        chk("reset.valid", 32'(evt_valid), 32'd0);
        chk("reset.btn",   32'(evt_btn),   32'd0);
        chk("reset.type",  32'(evt_type),  32'd0);
        chk("reset.held",  32'(btn_held),  32'd0);
        chk("reset.ovf",   32'(evt_ovf),   32'd0);
        rst_n = 1'b1;
        step(2);

        // 1: short press of button 0
        pb_db = 4'b1110;
        step(1); expect_none("t1_e0"); chk("t1_held", 32'(btn_held), 32'h1);
        step(1); expect_evt("t1_press", 0, 0);
        step(1); pb_db = 4'hF;
        step(1); expect_none("t1_gap");
        step(1); expect_evt("t1_rel", 0, 1);
        step(1); expect_none("t1_idle"); chk("t1_ovf", 32'(evt_ovf), 32'd0);
        step(3);

        // 2: long hold of button 2
        pb_db = 4'b1011;
        step(2);  expect_evt("t2_press", 2, 0);
        step(8);  expect_evt("t2_long", 2, 2);
        step(1);  expect_none("t2_after_long");
        step(3);  expect_evt("t2_rpt1", 2, 3);
        step(4);  expect_evt("t2_rpt2", 2, 3);
        step(2);  pb_db = 4'hF;
        step(2);  expect_evt("t2_rel", 2, 1);
        step(3);

        // 3: simultaneous presses and round-robin order
        rst_n = 1'b0; step(2); rst_n = 1'b1; step(2);
        pb_db = 4'b0101;
        step(2); expect_evt("t3_p1", 1, 0);
        step(1); expect_evt("t3_p3", 3, 0);
        step(1); pb_db = 4'hF;
        step(2); expect_evt("t3_r1", 1, 1);
        step(1); expect_evt("t3_r3", 3, 1);
        step(1); pb_db = 4'b1101;
        step(2); expect_evt("t3_solo", 1, 0);
        step(1); pb_db = 4'hF;
        step(2); expect_evt("t3_solo_rel", 1, 1);
        step(1); pb_db = 4'b0101;
        step(2); expect_evt("t3_rr3", 3, 0);
        step(1); expect_evt("t3_rr1", 1, 0);
        step(1); pb_db = 4'hF;
        step(4);

        // 4: back-pressure, coalescing and overflow clear
        evt_ready = 1'b0; pb_db = 4'b1110;
        step(2); expect_evt("t4_stall0", 0, 0); pb_db = 4'hF;
        step(1); expect_evt("t4_stall1", 0, 0); pb_db = 4'b1110;
        step(1); pb_db = 4'hF;
        step(1); pb_db = 4'b1110;
        step(1); expect_evt("t4_stall2", 0, 0); chk("t4_ovf_set", 32'(evt_ovf), 32'd1); pb_db = 4'hF;
        step(1); evt_ready = 1'b1;
        step(1); expect_evt("t4_drain_p", 0, 0);
        step(1); expect_evt("t4_drain_r", 0, 1);
        step(1); expect_none("t4_empty"); chk("t4_ovf_hold", 32'(evt_ovf), 32'd1); ovf_clr = 1'b1;
        step(1); ovf_clr = 1'b0; chk("t4_ovf_clr", 32'(evt_ovf), 32'd0);
        step(3);

        // 5: key held through reset is locked out
        pb_db = 4'b1110; rst_n = 1'b0;
        step(2); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1); expect_none("t5_lock");
        end
        pb_db = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step(1); expect_none("t5_unlock");
        end
        pb_db = 4'b1110;
        step(2); expect_evt("t5_press", 0, 0);
        step(1); pb_db = 4'hF;
        step(2); expect_evt("t5_rel", 0, 1);
        step(3);

        // 6: reset discards an in-flight event and pending bits
        evt_ready = 1'b0; pb_db = 4'b1101;
        step(2); expect_evt("t6_inflight", 1, 0); pb_db = 4'hF;
        step(1); rst_n = 1'b0;
        step(1); expect_none("t6_rst"); chk("t6_held", 32'(btn_held), 32'd0);
        chk("t6_ovf", 32'(evt_ovf), 32'd0);
        rst_n = 1'b1; evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1); expect_none("t6_cleared");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
